// File: rtl/closest_hit_select.sv
// closest_hit_select
//
// Per-pixel closest-intersection reducer. After a start, accepts NUM_OBJ
// intersection samples (one per scene object, in object order) and keeps
// the nearest valid positive distance and its object index. The result is
// presented on registered outputs with a one-cycle WritePixel strobe and is
// held until the next pixel completes.
//
// Build option:
//   CLOSEST_HIT_EPS_EN  when defined, a sample must exceed T_EPS (instead of
//                       0) to count as a hit, suppressing self-intersection.
//
// Ports:
//   Clk         system clock
//   Reset       synchronous, active-high reset
//   start       begin a pixel (accepted only when idle)
//   PixelX/Y    pixel coordinates, latched on an accepted start
//   t_valid     intersection sample present
//   t_in        signed Q32.32 distance
//   t_hit       geometric hit flag for the sample
//   t_ready     block accepts samples (collecting)
//   tbest       nearest accepted distance, or T_MISS
//   best_out    index of the nearest object, 0 on a miss
//   WriteX/Y    coordinates of the emitted pixel
//   WritePixel  one-cycle result strobe
//   busy        pixel in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// COLLECT | accepting one sample per object, tracking the nearest hit
// EMIT    | result on outputs, WritePixel high for this single cycle

module closest_hit_select #(
    parameter int          NUM_OBJ = 4,
    parameter int          IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
    parameter logic [63:0] T_MISS  = 64'hEFFFFFFFFFFFFFFF
`ifdef CLOSEST_HIT_EPS_EN
    ,
    parameter logic [63:0] T_EPS   = 64'h0000000000010000
`endif
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [9:0]       PixelX,
    input  logic [9:0]       PixelY,
    input  logic             t_valid,
    input  logic [63:0]      t_in,
    input  logic             t_hit,
    output logic             t_ready,
    output logic [63:0]      tbest,
    output logic [IDX_W-1:0] best_out,
    output logic [9:0]       WriteX,
    output logic [9:0]       WriteY,
    output logic             WritePixel,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [63:0]      best_q;
    logic [IDX_W-1:0] idx_q;
    logic             found_q;
    logic [9:0]       px_q, py_q;

    logic             start_acc;
    logic             sample_acc;
    logic             last_sample;
    logic             pos_ok;
    logic             cand;
    logic [63:0]      best_d;
    logic [IDX_W-1:0] idx_d;

    assign start_acc   = (state_q == S_IDLE) && start;
    assign sample_acc  = (state_q == S_COLLECT) && t_valid;
    assign last_sample = sample_acc && (cnt_q == LAST_IDX);

`ifdef CLOSEST_HIT_EPS_EN
    assign pos_ok = $signed(t_in) > $signed(T_EPS);
`else
    assign pos_ok = $signed(t_in) > 64'sd0;
`endif

    // T_MISS is negative when read as signed, so a plain "t_in < best"
    // against the sentinel would reject every positive distance. found_q
    // marks that the working best holds a real distance; until then any
    // qualifying hit is taken.
    assign cand   = sample_acc && t_hit && pos_ok &&
                    (!found_q || ($signed(t_in) < $signed(best_q)));
    assign best_d = cand ? t_in  : best_q;
    assign idx_d  = cand ? cnt_q : idx_q;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start)       state_d = S_COLLECT;
            S_COLLECT: if (last_sample) state_d = S_EMIT;
            S_EMIT:                     state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        t_ready    = 1'b0;
        busy       = 1'b0;
        WritePixel = 1'b0;
        case (state_q)
            S_COLLECT: begin
                t_ready = 1'b1;
                busy    = 1'b1;
            end
            S_EMIT: begin
                busy       = 1'b1;
                WritePixel = 1'b1;
            end
            default: ;
        endcase
    end

    // Working registers and held result. The result registers load on the
    // edge that accepts the final sample (using that sample's contribution),
    // so they are already valid during the EMIT cycle alongside the strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q    <= '0;
            best_q   <= T_MISS;
            idx_q    <= '0;
            found_q  <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            tbest    <= T_MISS;
            best_out <= '0;
            WriteX   <= '0;
            WriteY   <= '0;
        end else if (start_acc) begin
            cnt_q   <= '0;
            best_q  <= T_MISS;
            idx_q   <= '0;
            found_q <= 1'b0;
            px_q    <= PixelX;
            py_q    <= PixelY;
        end else if (sample_acc) begin
            cnt_q   <= cnt_q + 1'b1;
            best_q  <= best_d;
            idx_q   <= idx_d;
            found_q <= found_q | cand;
            if (last_sample) begin
                tbest    <= best_d;
                best_out <= idx_d;
                WriteX   <= px_q;
                WriteY   <= py_q;
            end
        end
    end

endmodule
